// File: rtl/rtc_bus_scheduler_if.sv
// Purpose : bundles the control, bus-engine and shadow-file signals of rtc_bus_scheduler.
// Latency : none (wires only).
// Backpressure: wr_req is held until wr_ack; txn_start/txn_done form a start/complete pair.
//
// Modports:
//   master - the scheduler (drives wr_ack, txn_*, shadow, sweep_done, busy, err)
//   slave  - its environment: edit logic, bus engine and character generator
interface rtc_bus_scheduler_if;
    logic        refresh_tick;
    logic [1:0]  edit_mode;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        txn_start;
    logic        txn_we;
    logic [7:0]  txn_addr;
    logic [7:0]  txn_wdata;
    logic        txn_done;
    logic [7:0]  txn_rdata;
    logic [71:0] shadow;
    logic        sweep_done;
    logic        busy;
    logic        err;
    logic        err_clr;

    modport master (
        input  refresh_tick, edit_mode, wr_req, wr_addr, wr_data,
               txn_done, txn_rdata, err_clr,
        output wr_ack, txn_start, txn_we, txn_addr, txn_wdata,
               shadow, sweep_done, busy, err
    );

    modport slave (
        output refresh_tick, edit_mode, wr_req, wr_addr, wr_data,
               txn_done, txn_rdata, err_clr,
        input  wr_ack, txn_start, txn_we, txn_addr, txn_wdata,
               shadow, sweep_done, busy, err
    );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// Purpose : sequences RTC bus accesses: periodic read sweep of 9 time registers into a
//           shadow file, edit-mode writes arbitrated at transaction boundaries, frozen edit group.
// Latency : uncontended read = SEL + ISSUE + bus latency per register; writes win every boundary.
// Backpressure: one transaction in flight; wr_req held until wr_ack; refresh ticks collapse to 1 pending.
//
// Ports: clk, reset (synchronous, active-high), bus (rtc_bus_scheduler_if.master).
// Optional feature: define RTC_BCD_CHECK_EN to reject read data with a nibble above 9
// (entry left unchanged, err set, sweep continues). Undefined: reads load unconditionally.
module rtc_bus_scheduler #(
    parameter int         NUM_REGS = 9,
    parameter logic [7:0] RTC_BASE = 8'h21,
    parameter logic [7:0] TMR_BASE = 8'h41,
    parameter int         TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,
    rtc_bus_scheduler_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REGS + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS);
    localparam logic [IDX_W-1:0] IDX_MIN_M = IDX_W'(3);   // first index of the date group
    localparam logic [IDX_W-1:0] IDX_MIN_T = IDX_W'(6);   // first index of the timer group
    localparam logic [IDX_W-1:0] IDX_MAX_T = IDX_W'(8);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SEL      = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_WR_ISSUE = 3'd4;
    localparam logic [2:0] S_WR_WAIT  = 3'd5;

    logic [2:0]                 state;
    logic [IDX_W-1:0]           idx;
    logic                       refresh_pending;
    logic                       sweep_active;
    logic [CNT_W-1:0]           tmo_cnt;
    logic [NUM_REGS-1:0][7:0]   shadow_q;
    logic                       txn_we_q;
    logic [7:0]                 txn_addr_q;
    logic [7:0]                 txn_wdata_q;
    logic                       err_q;

    logic                       tmo;
    logic                       rd_ok;
    logic                       err_set;
    logic                       wr_hit;
    logic [IDX_W-1:0]           wr_hit_idx;

    // Bus address of shadow index i: 0-5 live in the RTC block, 6-8 in the timer block.
    function automatic logic [7:0] map_addr(input logic [IDX_W-1:0] i);
        if (i < IDX_MIN_T)
            map_addr = RTC_BASE + 8'(i);
        else
            map_addr = TMR_BASE + 8'(i - IDX_MIN_T);
    endfunction

    // The group under edit is left alone so the user's value is not overwritten on screen.
    function automatic logic is_frozen(input logic [1:0] em, input logic [IDX_W-1:0] i);
        case (em)
            2'd3:    is_frozen = (i < IDX_MIN_M);
            2'd2:    is_frozen = (i >= IDX_MIN_M) && (i < IDX_MIN_T);
            2'd1:    is_frozen = (i >= IDX_MIN_T) && (i <= IDX_MAX_T);
            default: is_frozen = 1'b0;
        endcase
    endfunction

`ifdef RTC_BCD_CHECK_EN
    assign rd_ok = (bus.txn_rdata[7:4] <= 4'd9) && (bus.txn_rdata[3:0] <= 4'd9);
`else
    assign rd_ok = 1'b1;
`endif

    // Counter holds the number of completed wait cycles; the TIMEOUT-th waiting cycle aborts.
    assign tmo = (tmo_cnt == TMO_LAST) && !bus.txn_done;

    assign err_set = ((state == S_RD_WAIT) && (tmo || (bus.txn_done && !rd_ok))) ||
                     ((state == S_WR_WAIT) && tmo);

    // Reverse map of the latched write address onto the shadow file.
    always_comb begin
        wr_hit     = 1'b0;
        wr_hit_idx = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (txn_addr_q == map_addr(IDX_W'(i))) begin
                wr_hit     = 1'b1;
                wr_hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            idx             <= '0;
            refresh_pending <= 1'b0;
            sweep_active    <= 1'b0;
            tmo_cnt         <= '0;
            shadow_q        <= '0;
            txn_we_q        <= 1'b0;
            txn_addr_q      <= 8'h00;
            txn_wdata_q     <= 8'h00;
            err_q           <= 1'b0;
        end else begin
            // A fresh error outranks a clear issued in the same cycle.
            if (err_set)
                err_q <= 1'b1;
            else if (bus.err_clr)
                err_q <= 1'b0;

            // Tick while busy (or while a write is taking IDLE) is remembered once.
            if (bus.refresh_tick && ((state != S_IDLE) || bus.wr_req))
                refresh_pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (bus.wr_req) begin
                        state        <= S_WR_ISSUE;
                        sweep_active <= 1'b0;
                        txn_we_q     <= 1'b1;
                        txn_addr_q   <= bus.wr_addr;
                        txn_wdata_q  <= bus.wr_data;
                    end else if (bus.refresh_tick || refresh_pending) begin
                        state           <= S_SEL;
                        idx             <= '0;
                        refresh_pending <= 1'b0;
                        sweep_active    <= 1'b1;
                    end
                end

                S_SEL: begin
                    if (bus.wr_req) begin
                        state       <= S_WR_ISSUE;
                        txn_we_q    <= 1'b1;
                        txn_addr_q  <= bus.wr_addr;
                        txn_wdata_q <= bus.wr_data;
                    end else if (idx == LAST_IDX) begin
                        state        <= S_IDLE;
                        sweep_active <= 1'b0;
                    end else if (is_frozen(bus.edit_mode, idx)) begin
                        idx <= idx + IDX_W'(1);
                    end else begin
                        state      <= S_RD_ISSUE;
                        txn_we_q   <= 1'b0;
                        txn_addr_q <= map_addr(idx);
                    end
                end

                S_RD_ISSUE: begin
                    state   <= S_RD_WAIT;
                    tmo_cnt <= '0;
                end

                S_RD_WAIT: begin
                    if (bus.txn_done) begin
                        if (rd_ok)
                            shadow_q[idx] <= bus.txn_rdata;
                        idx   <= idx + IDX_W'(1);
                        state <= S_SEL;
                    end else if (tmo) begin
                        idx   <= idx + IDX_W'(1);
                        state <= S_SEL;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                S_WR_ISSUE: begin
                    state   <= S_WR_WAIT;
                    tmo_cnt <= '0;
                end

                S_WR_WAIT: begin
                    if (bus.txn_done || tmo) begin
                        // Completed writes to a mapped register show up on screen at once;
                        // a timed-out write is dropped.
                        if (bus.txn_done && wr_hit)
                            shadow_q[wr_hit_idx] <= txn_wdata_q;
                        state <= sweep_active ? S_SEL : S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.txn_start  = (state == S_RD_ISSUE) || (state == S_WR_ISSUE);
    assign bus.txn_we     = txn_we_q;
    assign bus.txn_addr   = txn_addr_q;
    assign bus.txn_wdata  = txn_wdata_q;
    assign bus.wr_ack     = (state == S_WR_WAIT) && (bus.txn_done || tmo);
    assign bus.sweep_done = (state == S_SEL) && !bus.wr_req && (idx == LAST_IDX);
    assign bus.busy       = (state != S_IDLE);
    assign bus.err        = err_q;
    assign bus.shadow     = shadow_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Purpose : self-checking bench for rtc_bus_scheduler with a bus-engine model.
// Latency : bus engine answers a configurable number of cycles after txn_start.
// Backpressure: requester holds wr_req until wr_ack; reads to drop_addr can be withheld.
module tb_rtc_bus_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rtc_bus_scheduler_if bus();

    rtc_bus_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef RTC_BCD_CHECK_EN
    localparam bit BCD_EN = 1'b1;
`else
    localparam bit BCD_EN = 1'b0;
`endif

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    typedef struct {
        logic [1:0] em;
        int         n_reads;
        logic [7:0] first_addr;
        logic [7:0] last_addr;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_sweep_done = 0;
    int         n_wr_ack     = 0;
    int         lat      = 2;
    logic       drop_en  = 1'b0;
    logic [7:0] drop_addr = 8'h00;
    logic [7:0] rd_val [256];
    txn_t       log_q [$];
    logic [7:0] exp_addrs [$];
    logic [7:0] exp_sh [9];
    logic       exp_err;

    // ---------------- bus engine model ----------------
    initial begin
        txn_t t;
        bus.txn_done  = 1'b0;
        bus.txn_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset && bus.txn_start) begin
                t.we = bus.txn_we; t.addr = bus.txn_addr; t.wdata = bus.txn_wdata;
                log_q.push_back(t);
                if (!(drop_en && !t.we && t.addr == drop_addr)) begin
                    repeat (lat) @(posedge clk);
                    #1;
                    bus.txn_done  = 1'b1;
                    bus.txn_rdata = t.we ? 8'h00 : rd_val[t.addr];
                    @(posedge clk);
                    #1;
                    bus.txn_done  = 1'b0;
                    bus.txn_rdata = 8'h00;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.sweep_done) n_sweep_done++;
            if (bus.wr_ack)     n_wr_ack++;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input int i);
        return (i < 6) ? 8'(8'h21 + i) : 8'(8'h41 + (i - 6));
    endfunction

    function automatic bit frozen(input int em, input int i);
        return (em == 3 && i < 3) || (em == 2 && i >= 3 && i < 6) || (em == 1 && i >= 6);
    endfunction

    function automatic bit bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [71:0] exp_shadow();
        logic [71:0] s;
        for (int i = 0; i < 9; i++) s[8*i +: 8] = exp_sh[i];
        return s;
    endfunction

    // Reference sweep: every non-frozen register is read once in index order.
    task automatic model_sweep(input int em, input int skip_idx);
        logic [7:0] v;
        for (int i = 0; i < 9; i++) begin
            if (!frozen(em, i)) begin
                exp_addrs.push_back(addr_of(i));
                v = rd_val[addr_of(i)];
                if (i == skip_idx)              exp_err = 1'b1;
                else if (!BCD_EN || bcd_ok(v))  exp_sh[i] = v;
                else                            exp_err = 1'b1;
            end
        end
    endtask

    task automatic pulse_refresh();
        bus.refresh_tick = 1'b1;
        @(posedge clk); #1;
        bus.refresh_tick = 1'b0;
    endtask

    task automatic pulse_err_clr();
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while (n_sweep_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, " sweep reached"}, 72'(n_sweep_done >= target), 72'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit with_tick,
                            input string name);
        int k = 0;
        bit seen = 1'b0;
        bus.wr_addr = a; bus.wr_data = d; bus.wr_req = 1'b1;
        if (with_tick) bus.refresh_tick = 1'b1;
        @(posedge clk); #1;
        bus.refresh_tick = 1'b0;
        while (!seen && k < 600) begin
            @(negedge clk);
            if (bus.wr_ack) seen = 1'b1;
            k++;
        end
        bus.wr_req = 1'b0;
        check({name, " wr_ack"}, 72'(seen), 72'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_reads(input string name, input int offset);
        check({name, " txn count"}, 72'(log_q.size()), 72'(exp_addrs.size() + offset));
        for (int i = 0; i < exp_addrs.size() && i + offset < log_q.size(); i++) begin
            check($sformatf("%s read%0d", name, i),
                  {63'd0, log_q[i + offset].we, log_q[i + offset].addr},
                  {63'd0, 1'b0, exp_addrs[i]});
        end
    endtask

    task automatic do_sweep(input string name, input int em);
        bus.edit_mode = 2'(em);
        log_q.delete(); exp_addrs.delete();
        n_sweep_done = 0;
        model_sweep(em, -1);
        pulse_refresh();
        wait_done(1, 3000, name);
        check_reads(name, 0);
        check({name, " shadow"}, bus.shadow, exp_shadow());
        check({name, " err"}, 72'(bus.err), 72'(exp_err));
        check({name, " sweep_done pulses"}, 72'(n_sweep_done), 72'd1);
        check({name, " busy"}, 72'(bus.busy), 72'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t tbl [4];
        logic [7:0] prev0;
        int k;

        tbl[0] = '{em: 2'd0, n_reads: 9, first_addr: 8'h21, last_addr: 8'h43};
        tbl[1] = '{em: 2'd3, n_reads: 6, first_addr: 8'h24, last_addr: 8'h43};
        tbl[2] = '{em: 2'd2, n_reads: 6, first_addr: 8'h21, last_addr: 8'h43};
        tbl[3] = '{em: 2'd1, n_reads: 6, first_addr: 8'h21, last_addr: 8'h26};

        for (int a = 0; a < 256; a++) rd_val[a] = 8'h00;
        for (int i = 0; i < 9; i++) exp_sh[i] = 8'h00;
        exp_err = 1'b0;

        reset = 1'b1;
        bus.refresh_tick = 1'b0; bus.edit_mode = 2'd0; bus.wr_req = 1'b0;
        bus.wr_addr = 8'h00; bus.wr_data = 8'h00; bus.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("reset shadow", bus.shadow, 72'd0);
        check("reset outs", {63'd0, bus.busy, bus.err, bus.txn_start, bus.wr_ack, bus.sweep_done,
                             bus.txn_we, 3'd0}, 72'd0);
        check("reset txn_addr", 72'(bus.txn_addr), 72'd0);

        // Table: one sweep per edit mode, rdata pattern differs per row.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 9; i++) rd_val[addr_of(i)] = 8'(8'h10 * (r + 1) + i);
            do_sweep($sformatf("tbl%0d", r), int'(tbl[r].em));
            check($sformatf("tbl%0d n_reads", r), 72'(log_q.size()), 72'(tbl[r].n_reads));
            if (log_q.size() > 0) begin
                check($sformatf("tbl%0d first", r), 72'(log_q[0].addr), 72'(tbl[r].first_addr));
                check($sformatf("tbl%0d last", r), 72'(log_q[log_q.size()-1].addr),
                      72'(tbl[r].last_addr));
            end
        end

        // Mid-sweep write: after the read of idx 2 is issued, a write to 0x22 preempts idx 3.
        for (int i = 0; i < 9; i++) rd_val[addr_of(i)] = 8'(8'h50 + i);
        bus.edit_mode = 2'd0;
        log_q.delete(); exp_addrs.delete();
        n_sweep_done = 0; n_wr_ack = 0;
        model_sweep(0, -1);
        exp_sh[1] = 8'h45;
        pulse_refresh();
        k = 0;
        while (log_q.size() < 3 && k < 200) begin @(posedge clk); #1; k++; end
        do_write(8'h22, 8'h45, 1'b0, "midwr");
        wait_done(1, 3000, "midwr");
        check("midwr txn count", 72'(log_q.size()), 72'd10);
        if (log_q.size() >= 5) begin
            check("midwr read idx2", 72'(log_q[2].addr), 72'h23);
            check("midwr write", {55'd0, log_q[3].we, log_q[3].addr, log_q[3].wdata},
                  {55'd0, 1'b1, 8'h22, 8'h45});
            check("midwr resume", {63'd0, log_q[4].we, log_q[4].addr}, {63'd0, 1'b0, 8'h24});
        end
        check("midwr ack pulses", 72'(n_wr_ack), 72'd1);
        check("midwr shadow", bus.shadow, exp_shadow());

        // Write and tick together in IDLE: write first, then a sweep with the timer frozen.
        for (int i = 0; i < 9; i++) rd_val[addr_of(i)] = 8'(8'h60 + i);
        bus.edit_mode = 2'd1;
        log_q.delete(); exp_addrs.delete();
        n_sweep_done = 0;
        exp_sh[8] = 8'h77;
        model_sweep(1, -1);
        do_write(8'h43, 8'h77, 1'b1, "wrtick");
        wait_done(1, 3000, "wrtick");
        if (log_q.size() > 0)
            check("wrtick first txn", {55'd0, log_q[0].we, log_q[0].addr, log_q[0].wdata},
                  {55'd0, 1'b1, 8'h43, 8'h77});
        check_reads("wrtick", 1);
        check("wrtick shadow", bus.shadow, exp_shadow());

        // Three ticks during a sweep collapse into exactly one extra sweep.
        for (int i = 0; i < 9; i++) rd_val[addr_of(i)] = 8'(8'h70 + i);
        bus.edit_mode = 2'd0;
        log_q.delete(); exp_addrs.delete();
        n_sweep_done = 0;
        model_sweep(0, -1);
        model_sweep(0, -1);
        pulse_refresh();
        for (int t = 0; t < 3; t++) begin
            repeat (4) @(posedge clk);
            #1 pulse_refresh();
        end
        wait_done(2, 3000, "ticks3");
        repeat (100) @(posedge clk);
        #1;
        check("ticks3 sweeps", 72'(n_sweep_done), 72'd2);
        check_reads("ticks3", 0);
        check("ticks3 busy", 72'(bus.busy), 72'd0);

        // Withheld txn_done on 0x24: timeout, entry kept, sweep continues.
        for (int i = 0; i < 9; i++) rd_val[addr_of(i)] = 8'(8'h80 + i);
        drop_en = 1'b1; drop_addr = 8'h24;
        log_q.delete(); exp_addrs.delete();
        n_sweep_done = 0;
        model_sweep(0, 3);
        pulse_refresh();
        k = 0;
        while (log_q.size() < 4 && k < 200) begin @(posedge clk); #1; k++; end
        repeat (250) @(posedge clk);
        #1;
        check("tmo err early", 72'(bus.err), 72'd0);
        repeat (10) @(posedge clk);
        #1;
        check("tmo err set", 72'(bus.err), 72'd1);
        wait_done(1, 3000, "tmo");
        drop_en = 1'b0;
        check_reads("tmo", 0);
        check("tmo shadow", bus.shadow, exp_shadow());
        check("tmo err held", 72'(bus.err), 72'd1);
        pulse_err_clr();
        check("tmo err_clr", 72'(bus.err), 72'd0);

        // Non-BCD read data on idx 0.
        for (int i = 0; i < 9; i++) rd_val[addr_of(i)] = 8'(8'h30 + i);
        rd_val[8'h21] = 8'h3A;
        prev0 = exp_sh[0];
        do_sweep("bcd", 0);
        check("bcd shadow0", 72'(bus.shadow[7:0]), BCD_EN ? 72'(prev0) : 72'h3A);
        check("bcd err", 72'(bus.err), BCD_EN ? 72'd1 : 72'd0);
        pulse_err_clr();

        // Randomized sweeps and idle writes against the reference model.
        for (int it = 0; it < 8; it++) begin
            int widx;
            logic [7:0] wd;
            lat = int'($urandom_range(4, 1));
            for (int i = 0; i < 9; i++) rd_val[addr_of(i)] = 8'($urandom);
            pulse_err_clr();
            do_sweep($sformatf("rnd%0d", it), int'($urandom_range(3, 0)));
            widx = int'($urandom_range(8, 0));
            wd   = 8'($urandom);
            exp_sh[widx] = wd;
            do_write(addr_of(widx), wd, 1'b0, $sformatf("rndwr%0d", it));
            check($sformatf("rndwr%0d shadow", it), bus.shadow, exp_shadow());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
